// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: groups the next-PC controller's request, stall and PC
// signals into one bundle.
//   slave  modport - the pc_sequencer side (requests in, pc_next/flags out)
//   master modport - the execute/CSR/PC-register side driving the requests
// Signals:
//   stall, if_buffer_stall, if_load_stall : hold sources
//   pc_reg                                : current PC from the PC register
//   br_taken/br_target, jmp_valid/jmp_target, trap_req/trap_vector,
//   mret_req/mepc                         : redirect sources
//   pc_next, pc_hold, flush, trap_ack, redirect, pend_valid : controller outputs
interface pc_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 64
);
  logic                  stall;
  logic                  if_buffer_stall;
  logic                  if_load_stall;
  logic [ADDR_WIDTH-1:0] pc_reg;
  logic                  br_taken;
  logic [ADDR_WIDTH-1:0] br_target;
  logic                  jmp_valid;
  logic [ADDR_WIDTH-1:0] jmp_target;
  logic                  trap_req;
  logic [ADDR_WIDTH-1:0] trap_vector;
  logic                  mret_req;
  logic [ADDR_WIDTH-1:0] mepc;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  pc_hold;
  logic                  flush;
  logic                  trap_ack;
  logic                  redirect;
  logic                  pend_valid;

  modport master (
    output stall, if_buffer_stall, if_load_stall, pc_reg,
           br_taken, br_target, jmp_valid, jmp_target,
           trap_req, trap_vector, mret_req, mepc,
    input  pc_next, pc_hold, flush, trap_ack, redirect, pend_valid
  );

  modport slave (
    input  stall, if_buffer_stall, if_load_stall, pc_reg,
           br_taken, br_target, jmp_valid, jmp_target,
           trap_req, trap_vector, mret_req, mepc,
    output pc_next, pc_hold, flush, trap_ack, redirect, pend_valid
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the fetch stage.
// Selects pc_next from sequential increment, branch/jump, trap entry and
// trap return (priority trap > mret > branch > jump > sequential), merges
// the stall sources into pc_hold, latches redirects that arrive while held
// and raises flush for FLUSH_CYCLES cycles after every applied redirect.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : pc_sequencer_if.slave (requests, stalls, pc_reg in; pc_next,
//           pc_hold, flush, trap_ack, redirect, pend_valid out)
module pc_sequencer #(
  parameter int unsigned           ADDR_WIDTH   = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR   = '0,
  parameter int unsigned           FLUSH_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_RUN, S_PEND, S_FLUSH} state_t;
  // Encoded so that a numerically larger class has higher priority.
  typedef enum logic [2:0] {SRC_NONE, SRC_JMP, SRC_BR, SRC_MRET, SRC_TRAP} src_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t                state, state_n;
  logic [2:0]            cnt, cnt_n;
  src_t                  pend_src, pend_src_n;
  logic [ADDR_WIDTH-1:0] pend_tgt, pend_tgt_n;

  logic                  hold;
  logic [ADDR_WIDTH-1:0] seq_pc;
  src_t                  cur_src;
  logic [ADDR_WIDTH-1:0] cur_raw, cur_tgt;
  logic                  do_apply;
  src_t                  app_src;
  logic [ADDR_WIDTH-1:0] app_tgt;
  logic [ADDR_WIDTH-1:0] nxt_pc;

  // RESET_ADDR documents the PC register's reset value; nothing here uses it.
  logic unused_reset_addr;
  assign unused_reset_addr = ^RESET_ADDR;

  assign hold   = bus.stall | bus.if_buffer_stall | bus.if_load_stall;
  assign seq_pc = bus.pc_reg + ADDR_WIDTH'(4);

  // Highest-priority request this cycle; during FLUSH only a trap counts.
  always_comb begin
    cur_src = SRC_NONE;
    cur_raw = '0;
    if (bus.trap_req) begin
      cur_src = SRC_TRAP;
      cur_raw = bus.trap_vector;
    end else if (state != S_FLUSH) begin
      if (bus.mret_req) begin
        cur_src = SRC_MRET;
        cur_raw = bus.mepc;
      end else if (bus.br_taken) begin
        cur_src = SRC_BR;
        cur_raw = bus.br_target;
      end else if (bus.jmp_valid) begin
        cur_src = SRC_JMP;
        cur_raw = bus.jmp_target;
      end
    end
    cur_tgt = {cur_raw[ADDR_WIDTH-1:1], 1'b0};
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pend_src_n = pend_src;
    pend_tgt_n = pend_tgt;
    nxt_pc     = seq_pc;
    do_apply   = 1'b0;
    app_src    = cur_src;
    app_tgt    = cur_tgt;

    unique case (state)
      S_RUN: begin
        if (cur_src != SRC_NONE) begin
          if (!hold) begin
            do_apply = 1'b1;
          end else begin
            pend_src_n = cur_src;
            pend_tgt_n = cur_tgt;
            nxt_pc     = cur_tgt;
            state_n    = S_PEND;
          end
        end
      end
      S_PEND: begin
        // Pending entry survives ties; only a strictly higher class replaces it.
        if (!(cur_src > pend_src)) begin
          app_src = pend_src;
          app_tgt = pend_tgt;
        end
        if (!hold) begin
          do_apply = 1'b1;
        end else begin
          pend_src_n = app_src;
          pend_tgt_n = app_tgt;
          nxt_pc     = app_tgt;
        end
      end
      S_FLUSH: begin
        cnt_n = (cnt != '0) ? cnt - 3'd1 : '0;
        if (cur_src == SRC_TRAP) begin
          if (!hold) begin
            do_apply = 1'b1;
          end else if (pend_src != SRC_TRAP) begin
            pend_src_n = SRC_TRAP;
            pend_tgt_n = cur_tgt;
          end
        end
        if (!do_apply && cnt <= 3'd1) begin
          state_n = (pend_src_n != SRC_NONE) ? S_PEND : S_RUN;
        end
      end
      default: state_n = S_RUN;
    endcase

    if (do_apply) begin
      nxt_pc     = app_tgt;
      state_n    = S_FLUSH;
      cnt_n      = FLUSH_LOAD;
      pend_src_n = SRC_NONE;
      pend_tgt_n = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_RUN;
      cnt      <= '0;
      pend_src <= SRC_NONE;
      pend_tgt <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pend_src <= pend_src_n;
      pend_tgt <= pend_tgt_n;
    end
  end

  // Combinational pulses are masked while reset is asserted so a request
  // present during reset cannot leak out as a redirect.
  assign bus.pc_next    = reset ? seq_pc : nxt_pc;
  assign bus.pc_hold    = hold;
  assign bus.redirect   = do_apply & ~reset;
  assign bus.trap_ack   = do_apply & (app_src == SRC_TRAP) & ~reset;
  assign bus.flush      = (cnt != '0);
  assign bus.pend_valid = (pend_src != SRC_NONE);

endmodule
